// File: rtl/shifter32_deser.sv
// shifter32_deser: serial-to-parallel receiver for the shifter32 bit stream.
// Rebuilds WIDTH-bit words MSB- or LSB-first into a one-deep valid/ready output register.
module shifter32_deser #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_next;
    logic             dir_q;
    logic             dir_eff;
    logic             first_bit;
    logic             last_bit;
    logic             complete;
    logic             load;
    logic             drop;

    // A sync'd bit starts a fresh word, so it shifts into an empty register
    assign first_bit = (bit_cnt == '0) || sync;
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign complete  = sin_valid && !sync && last_bit;
    assign dir_eff   = first_bit ? msb_first : dir_q;
    assign sr_base   = sync ? '0 : sr;
    assign sr_next   = dir_eff ? {sr_base[WIDTH-2:0], sin}
                               : {sin, sr_base[WIDTH-1:1]};
    assign out_valid = (state == FULL);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    load = out_ready;
                    drop = !out_ready;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_d;
            if (load) begin
                data_out <= sr_next;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
        end else if (sync) begin
            if (sin_valid) begin
                sr      <= sr_next;
                bit_cnt <= CNT_W'(1);
                dir_q   <= msb_first;
            end else begin
                sr      <= '0;
                bit_cnt <= '0;
            end
        end else if (sin_valid) begin
            if (first_bit) begin
                dir_q <= msb_first;
            end
            if (last_bit) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else begin
                sr      <= sr_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shifter32_deser.sv
// Bench for shifter32_deser: table-driven words checked through a scoreboard,
// then hand-written sequences for backpressure, sync and reset corners.
module tb_shifter32_deser;

    logic        clk;
    logic        reset;
    logic        sin;
    logic        sin_valid;
    logic        msb_first;
    logic        sync;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        clr_ovr;
    logic [5:0]  bit_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] word;
        logic        msb;
        int          gap;
        logic        tog;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    shifter32_deser #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .msb_first(msb_first), .sync(sync), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
        .clr_ovr(clr_ovr), .bit_cnt(bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer side: every handshake pops one expected word
    always @(posedge clk) begin
        #2;
        if (mon_en && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", data_out, 32'hx);
            end else begin
                chk("sb_word", data_out, sb_q.pop_front());
            end
        end
    end

    task automatic idle();
        sin_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic msb);
        sin       = b;
        sin_valid = 1'b1;
        msb_first = msb;
        @(negedge clk);
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic msb,
                             input int gap, input logic tog,
                             input logic rdy_last, input logic clr_last);
        logic keep;
        keep = out_ready;
        for (int i = 0; i < 32; i++) begin
            if (gap > 0 && (i % gap) == gap - 1) idle();
            if (i == 31) begin
                out_ready = rdy_last;
                clr_ovr   = clr_last;
            end
            send_bit(msb ? w[31-i] : w[i], (tog && i >= 10) ? ~msb : msb);
        end
        out_ready = keep;
        clr_ovr   = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        vecs[0] = '{32'h12345678, 1'b0, 3, 1'b1, 32'h12345678};
        vecs[1] = '{32'hA5A5F00F, 1'b1, 0, 1'b0, 32'hA5A5F00F};
        vecs[2] = '{32'hDEADBEEF, 1'b0, 0, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{32'h80000001, 1'b1, 2, 1'b0, 32'h80000001};
        vecs[4] = '{32'h00000000, 1'b0, 0, 1'b0, 32'h00000000};
        vecs[5] = '{32'hFFFFFFFF, 1'b1, 5, 1'b1, 32'hFFFFFFFF};
        vecs[6] = '{32'h0000FFFE, 1'b1, 0, 1'b1, 32'h0000FFFE};
        vecs[7] = '{32'h7FFF0001, 1'b0, 4, 1'b0, 32'h7FFF0001};

        reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; msb_first = 1'b0;
        sync = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_cnt", {26'h0, bit_cnt}, 32'h0);
        chk("rst_ovr", {31'h0, overrun}, 32'h0);

        // Table: streamed back to back with the consumer always ready
        out_ready = 1'b1;
        mon_en    = 1'b1;
        foreach (vecs[k]) begin
            sb_q.push_back(vecs[k].exp);
            send_word(vecs[k].word, vecs[k].msb, vecs[k].gap, vecs[k].tog,
                      1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) idle();
        chk("sb_drained", sb_q.size(), 32'h0);
        chk("sb_no_ovr", {31'h0, overrun}, 32'h0);
        mon_en    = 1'b0;
        out_ready = 1'b0;

        // MSB-first word held by a stalled consumer
        send_word(32'hA5A5F00F, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("msb_valid", {31'h0, out_valid}, 32'h1);
        chk("msb_data", data_out, 32'hA5A5F00F);
        chk("msb_cnt", {26'h0, bit_cnt}, 32'h0);
        chk("msb_ovr", {31'h0, overrun}, 32'h0);
        out_ready = 1'b1; idle(); out_ready = 1'b0;
        chk("drain_valid", {31'h0, out_valid}, 32'h0);

        // Backpressure: second word is dropped
        send_word(32'h11111111, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("bp_data", data_out, 32'h11111111);
        chk("bp_ovr", {31'h0, overrun}, 32'h1);
        send_word(32'h44444444, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("bp_ovr_sticky", {31'h0, overrun}, 32'h1);
        chk("bp_data2", data_out, 32'h11111111);
        out_ready = 1'b1; idle(); out_ready = 1'b0;
        chk("bp_empty", {31'h0, out_valid}, 32'h0);
        chk("bp_ovr_kept", {31'h0, overrun}, 32'h1);
        clr_ovr = 1'b1; idle(); clr_ovr = 1'b0;
        chk("bp_clr", {31'h0, overrun}, 32'h0);
        out_ready = 1'b1; idle(); out_ready = 1'b0;
        chk("empty_rdy", {31'h0, out_valid}, 32'h0);

        // Drain and complete on the same edge
        send_word(32'hAAAAAAAA, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("dc_held", data_out, 32'hAAAAAAAA);
        send_word(32'h55555555, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("dc_valid", {31'h0, out_valid}, 32'h1);
        chk("dc_data", data_out, 32'h55555555);
        chk("dc_ovr", {31'h0, overrun}, 32'h0);

        // Drop coinciding with clr_ovr: the set wins
        send_word(32'h33333333, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        chk("setwin_ovr", {31'h0, overrun}, 32'h1);
        chk("setwin_data", data_out, 32'h55555555);
        out_ready = 1'b1; clr_ovr = 1'b1; idle();
        out_ready = 1'b0; clr_ovr = 1'b0;
        chk("setwin_clr", {31'h0, overrun}, 32'h0);
        chk("setwin_empty", {31'h0, out_valid}, 32'h0);

        // sync with the first bit of a new word after 13 stray bits
        for (int i = 0; i < 13; i++) send_bit(i[0], 1'b0);
        chk("sync_pre_cnt", {26'h0, bit_cnt}, 32'd13);
        w = 32'hDEADBEEF;
        sync = 1'b1;
        send_bit(w[31], 1'b1);
        sync = 1'b0;
        chk("sync_cnt", {26'h0, bit_cnt}, 32'd1);
        for (int i = 1; i < 32; i++) send_bit(w[31-i], 1'b0);
        chk("sync_valid", {31'h0, out_valid}, 32'h1);
        chk("sync_data", data_out, 32'hDEADBEEF);
        out_ready = 1'b1; idle(); out_ready = 1'b0;

        // Reset while FULL and 20 bits into the next word
        send_word(32'h0F0F0F0F, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1);
        chk("pre_rst_cnt", {26'h0, bit_cnt}, 32'd20);
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1; idle(); reset = 1'b0;
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_cnt", {26'h0, bit_cnt}, 32'h0);
        chk("mid_rst_ovr", {31'h0, overrun}, 32'h0);
        send_word(32'hC3C35A5A, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", data_out, 32'hC3C35A5A);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
